text_console_ctrl: RTL and testbench

- Sequences the write port of the tile screen buffer from a stream of ASCII bytes (e.g. UART RX).
- Tracks a cursor and handles printable characters, CR, LF, BS and FF.
- FF and reset trigger a full-screen blank sweep.
- Sits between the character source and the buffer write port (wr_en/col/row/din); the buffer read side is untouched.

---
 rtl/text_console_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : text_console_ctrl
// Brief    : Drives the tile screen buffer write port from an ASCII byte
//            stream, tracking a cursor and blanking the screen on reset/FF.
//            Optional macro LINE_CLEAR_EN blanks each newly entered row.
// Revision : 1.0
// ============================================================================
module text_console_ctrl #(
    parameter int H_TILES        = 175,
    parameter int V_TILES        = 65,
    parameter int ADDR_COL_WIDTH = 8,
    parameter int ADDR_ROW_WIDTH = 7,
    parameter int DATA_WIDTH     = 7,
    parameter int BLANK_CHAR     = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      char_valid_i,
    input  logic [7:0]                char_i,
    output logic                      char_ready_o,
    output logic                      wr_en_o,
    output logic [ADDR_COL_WIDTH-1:0] col_w_o,
    output logic [ADDR_ROW_WIDTH-1:0] row_w_o,
    output logic [DATA_WIDTH-1:0]     din_o,
    output logic [ADDR_COL_WIDTH-1:0] cur_col_o,
    output logic [ADDR_ROW_WIDTH-1:0] cur_row_o,
    output logic                      busy_o
);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
`ifdef LINE_CLEAR_EN
    localparam logic [1:0] ST_LCLR  = 2'd2;
`endif

    localparam logic [ADDR_COL_WIDTH-1:0] COL_LAST = ADDR_COL_WIDTH'(H_TILES - 1);
    localparam logic [ADDR_COL_WIDTH-1:0] COL_ONE  = ADDR_COL_WIDTH'(1);
    localparam logic [ADDR_ROW_WIDTH-1:0] ROW_LAST = ADDR_ROW_WIDTH'(V_TILES - 1);
    localparam logic [ADDR_ROW_WIDTH-1:0] ROW_ONE  = ADDR_ROW_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]     BLANK    = DATA_WIDTH'(BLANK_CHAR);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    logic [1:0]                state, state_nxt;
    logic [ADDR_COL_WIDTH-1:0] sweep_col, sweep_col_nxt;
    logic [ADDR_ROW_WIDTH-1:0] sweep_row, sweep_row_nxt;
    logic [ADDR_COL_WIDTH-1:0] cur_col_nxt;
    logic [ADDR_ROW_WIDTH-1:0] cur_row_nxt;
    logic                      wr_en_nxt;
    logic [ADDR_COL_WIDTH-1:0] col_w_nxt;
    logic [ADDR_ROW_WIDTH-1:0] row_w_nxt;
    logic [DATA_WIDTH-1:0]     din_nxt;
    logic                      printable;
    logic [ADDR_ROW_WIDTH-1:0] row_adv;

    assign printable = (char_i >= 8'h20) && (char_i <= 8'h7E);
    assign row_adv   = (cur_row_o == ROW_LAST) ? '0 : cur_row_o + ROW_ONE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_CLEAR;
            sweep_col <= '0;
            sweep_row <= '0;
            cur_col_o <= '0;
            cur_row_o <= '0;
            wr_en_o   <= 1'b0;
            col_w_o   <= '0;
            row_w_o   <= '0;
            din_o     <= '0;
        end else begin
            state     <= state_nxt;
            sweep_col <= sweep_col_nxt;
            sweep_row <= sweep_row_nxt;
            cur_col_o <= cur_col_nxt;
            cur_row_o <= cur_row_nxt;
            wr_en_o   <= wr_en_nxt;
            col_w_o   <= col_w_nxt;
            row_w_o   <= row_w_nxt;
            din_o     <= din_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_col_nxt = sweep_col;
        sweep_row_nxt = sweep_row;
        cur_col_nxt   = cur_col_o;
        cur_row_nxt   = cur_row_o;
        wr_en_nxt     = 1'b0;
        col_w_nxt     = col_w_o;
        row_w_nxt     = row_w_o;
        din_nxt       = din_o;
        case (state)
            ST_CLEAR: begin
                wr_en_nxt = 1'b1;
                col_w_nxt = sweep_col;
                row_w_nxt = sweep_row;
                din_nxt   = BLANK;
                if (sweep_col == COL_LAST) begin
                    sweep_col_nxt = '0;
                    if (sweep_row == ROW_LAST) begin
                        sweep_row_nxt = '0;
                        state_nxt     = ST_IDLE;
                    end else begin
                        sweep_row_nxt = sweep_row + ROW_ONE;
                    end
                end else begin
                    sweep_col_nxt = sweep_col + COL_ONE;
                end
            end
            ST_IDLE: begin
                if (char_valid_i) begin
                    if (printable) begin
                        wr_en_nxt = 1'b1;
                        col_w_nxt = cur_col_o;
                        row_w_nxt = cur_row_o;
                        din_nxt   = char_i[DATA_WIDTH-1:0];
                        if (cur_col_o == COL_LAST) begin
                            cur_col_nxt = '0;
                            cur_row_nxt = row_adv;
`ifdef LINE_CLEAR_EN
                            state_nxt     = ST_LCLR;
                            sweep_col_nxt = '0;
                            sweep_row_nxt = row_adv;
`endif
                        end else begin
                            cur_col_nxt = cur_col_o + COL_ONE;
                        end
                    end else if (char_i == CH_CR) begin
                        cur_col_nxt = '0;
                    end else if (char_i == CH_LF) begin
                        cur_row_nxt = row_adv;
`ifdef LINE_CLEAR_EN
                        state_nxt     = ST_LCLR;
                        sweep_col_nxt = '0;
                        sweep_row_nxt = row_adv;
`endif
                    end else if (char_i == CH_BS) begin
                        // Backspace at column 0 is a no-op: no reverse line wrap.
                        if (cur_col_o != '0) begin
                            cur_col_nxt = cur_col_o - COL_ONE;
                            wr_en_nxt   = 1'b1;
                            col_w_nxt   = cur_col_o - COL_ONE;
                            row_w_nxt   = cur_row_o;
                            din_nxt     = BLANK;
                        end
                    end else if (char_i == CH_FF) begin
                        cur_col_nxt   = '0;
                        cur_row_nxt   = '0;
                        sweep_col_nxt = '0;
                        sweep_row_nxt = '0;
                        state_nxt     = ST_CLEAR;
                    end
                end
            end
`ifdef LINE_CLEAR_EN
            ST_LCLR: begin
                wr_en_nxt = 1'b1;
                col_w_nxt = sweep_col;
                row_w_nxt = sweep_row;
                din_nxt   = BLANK;
                if (sweep_col == COL_LAST) begin
                    sweep_col_nxt = '0;
                    state_nxt     = ST_IDLE;
                end else begin
                    sweep_col_nxt = sweep_col + COL_ONE;
                end
            end
`endif
            default: begin
                state_nxt     = ST_CLEAR;
                sweep_col_nxt = '0;
                sweep_row_nxt = '0;
            end
        endcase
    end

    always_comb begin
        char_ready_o = (state == ST_IDLE);
        busy_o       = (state != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// Bench for text_console_ctrl: directed steps plus random bytes checked
// against a linear-index screen/cursor model.
module tb_text_console_ctrl;

    localparam int H = 175;
    localparam int V = 65;

    logic       clk = 1'b0;
    logic       rst;
    logic       char_valid;
    logic [7:0] char_b;
    logic       char_ready;
    logic       wr_en;
    logic [7:0] col_w;
    logic [6:0] row_w;
    logic [6:0] din;
    logic [7:0] cur_col;
    logic [6:0] cur_row;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int m_col = 0;
    int m_row = 0;

    always #4 clk = ~clk;

    text_console_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .char_valid_i (char_valid),
        .char_i       (char_b),
        .char_ready_o (char_ready),
        .wr_en_o      (wr_en),
        .col_w_o      (col_w),
        .row_w_o      (row_w),
        .din_o        (din),
        .cur_col_o    (cur_col),
        .cur_row_o    (cur_row),
        .busy_o       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: cursor as a linear screen index, stalls as cycle counts.
    task automatic model(input logic [7:0] b, output bit w, output int wc, output int wr,
                         output int wd, output int stall, output int srow);
        int idx;
        w = 0; wc = 0; wr = 0; wd = 0; stall = 0; srow = -1;
        if (b >= 8'h20 && b <= 8'h7E) begin
            w = 1; wc = m_col; wr = m_row; wd = int'(b) % 128;
            idx = (m_row * H + m_col + 1) % (H * V);
`ifdef LINE_CLEAR_EN
            if (idx / H != m_row) begin
                stall = H;
                srow  = idx / H;
            end
`endif
            m_col = idx % H;
            m_row = idx / H;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_row = (m_row + 1) % V;
`ifdef LINE_CLEAR_EN
            stall = H;
            srow  = m_row;
`endif
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col = m_col - 1;
                w = 1; wc = m_col; wr = m_row; wd = 0;
            end
        end else if (b == 8'h0C) begin
            m_col = 0; m_row = 0;
            stall = H * V;
        end
    endtask

    // Checks a blanking sweep of n writes; srow < 0 means the whole screen.
    task automatic check_sweep(input int n, input int srow);
        int bad = 0;
        int ec, er;
        for (int k = 0; k < n; k++) begin
            step();
            ec = (srow < 0) ? k % H : k;
            er = (srow < 0) ? k / H : srow;
            if (wr_en !== 1'b1 || int'(col_w) != ec || int'(row_w) != er || din !== 7'd0)
                bad++;
            if (k < n - 1 && (char_ready !== 1'b0 || busy !== 1'b1))
                bad++;
            if (int'(cur_col) != m_col || int'(cur_row) != m_row)
                bad++;
        end
        chk("sweep_bad_cycles", bad, 0);
        chk("sweep_end_ready", char_ready, 1);
        chk("sweep_end_busy", busy, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit w;
        int wc, wr, wd, stall, srow;
        chk("ready_before_byte", char_ready, 1);
        char_valid = 1'b1;
        char_b     = b;
        step();
        char_valid = 1'b0;
        model(b, w, wc, wr, wd, stall, srow);
        chk("byte_wr_en", wr_en, w);
        if (w) begin
            chk("byte_col", col_w, wc);
            chk("byte_row", row_w, wr);
            chk("byte_din", din, wd);
        end
        chk("byte_cur_col", cur_col, m_col);
        chk("byte_cur_row", cur_row, m_row);
        if (stall > 0) check_sweep(stall, srow);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if (r < 60)      b = 8'($urandom_range(32, 126));
        else if (r < 70) b = 8'h0D;
        else if (r < 80) b = 8'h0A;
        else if (r < 90) b = 8'h08;
        else begin
            b = 8'($urandom_range(0, 255));
            if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A ||
                b == 8'h0C || b == 8'h0D)
                b = 8'h7F;
        end
        return b;
    endfunction

    task automatic random_burst(input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(rand_byte());
            repeat ($urandom_range(0, 1)) begin
                step();
                chk("idle_no_write", wr_en, 0);
            end
        end
    endtask

    initial begin
        bit w;
        int wc, wr, wd, stall, srow;
        rst = 1'b1;
        char_valid = 1'b0;
        char_b = 8'h00;
        repeat (3) step();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_col", col_w, 0);
        chk("rst_row", row_w, 0);
        chk("rst_din", din, 0);
        chk("rst_cur_col", cur_col, 0);
        chk("rst_cur_row", cur_row, 0);
        chk("rst_ready", char_ready, 0);
        chk("rst_busy", busy, 1);
        rst = 1'b0;
        check_sweep(H * V, -1);

        send_byte(8'h41);
        chk("A_cur_col", cur_col, 1);
        chk("A_cur_row", cur_row, 0);

        random_burst(300);

        // Backspace in mid-line and at column 0.
        send_byte(8'h0D);
        while (m_row != 3) send_byte(8'h0A);
        repeat (5) send_byte(8'h61);
        send_byte(8'h08);
        chk("bs_cur_col", cur_col, 4);
        chk("bs_cur_row", cur_row, 3);
        send_byte(8'h0D);
        send_byte(8'h08);
        chk("bs0_cur_col", cur_col, 0);

        // CR then LF from (7,2).
        while (m_row != 2) send_byte(8'h0A);
        repeat (7) send_byte(8'h62);
        send_byte(8'h0D);
        send_byte(8'h0A);
        chk("crlf_cur_col", cur_col, 0);
        chk("crlf_cur_row", cur_row, 3);

        // Last tile of the screen wraps the cursor to the origin.
        while (m_row != V - 1) send_byte(8'h0A);
        send_byte(8'h0D);
        repeat (H - 1) send_byte(8'h78);
        send_byte(8'h5A);
        chk("wrap_cur_col", cur_col, 0);
        chk("wrap_cur_row", cur_row, 0);

        random_burst(100);

        // Form feed with valid held high: next byte waits out the sweep.
        chk("ff_ready_before", char_ready, 1);
        char_valid = 1'b1;
        char_b     = 8'h0C;
        step();
        model(8'h0C, w, wc, wr, wd, stall, srow);
        chk("ff_wr_en", wr_en, 0);
        chk("ff_ready_low", char_ready, 0);
        chk("ff_busy", busy, 1);
        char_b = 8'h42;
        check_sweep(stall, srow);
        step();
        char_valid = 1'b0;
        model(8'h42, w, wc, wr, wd, stall, srow);
        chk("ff_next_wr_en", wr_en, 1);
        chk("ff_next_col", col_w, 0);
        chk("ff_next_row", row_w, 0);
        chk("ff_next_din", din, 8'h42);
        chk("ff_next_cur_col", cur_col, 1);

        // Reset in the middle of a sweep zeroes outputs at once and restarts it.
        send_byte(8'h33);
        chk("ff2_ready_before", char_ready, 1);
        char_valid = 1'b1;
        char_b     = 8'h0C;
        step();
        char_valid = 1'b0;
        repeat (500) step();
        chk("midsweep_wr_en_before", wr_en, 1);
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_col", col_w, 0);
        chk("midrst_row", row_w, 0);
        chk("midrst_din", din, 0);
        chk("midrst_cur_col", cur_col, 0);
        chk("midrst_cur_row", cur_row, 0);
        chk("midrst_ready", char_ready, 0);
        chk("midrst_busy", busy, 1);
        step();
        step();
        rst = 1'b0;
        m_col = 0;
        m_row = 0;
        check_sweep(H * V, -1);

        random_burst(100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
